// File: rtl/sdram_resp_model.sv
`timescale 1ns/1ps
// Purpose: device-side SDRAM responder; decodes the controller command bus, keeps bank/mode state, stores/returns bursts.
// Latency: write beat stored the cycle it is sampled; read data leaves dq_out exactly CL cycles after each issued beat.
// Backpressure: none, the command bus is not flow-controlled; cke=0 freezes bursts. Timing checks: SDRAM_RESP_TIMING_CHK_EN.
module sdram_resp_model #(
  parameter int MEM_AW    = 14,
  parameter int INIT_REFS = 2,
  parameter int TRCD      = 3,
  parameter int TRP       = 3,
  parameter int TRFC      = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdram_cke,
  input  logic        sdram_cs_n,
  input  logic        sdram_ras_n,
  input  logic        sdram_cas_n,
  input  logic        sdram_we_n,
  input  logic [1:0]  sdram_ba,
  input  logic [11:0] sdram_addr,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic        init_done,
  output logic        proto_err,
  output logic        timing_err
);

  localparam int RW  = MEM_AW - 10;            // row bits that reach the array
  localparam int RCW = $clog2(INIT_REFS + 1);
  localparam logic [RCW-1:0] REFS_LAST = RCW'(INIT_REFS - 1);

  localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD  = 3'b101, C_WR  = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010, C_REF = 3'b001, C_MRS = 3'b000, C_BST = 3'b110;

  typedef enum logic [1:0] {I_PRE, I_REF, I_MRS, READY} init_t;

  init_t          state, state_nxt;
  logic [RCW-1:0] ref_cnt, ref_cnt_nxt;

  logic [15:0] mem [2**MEM_AW];

  logic [3:0]  bank_open;
  logic [11:0] open_row [4];
  logic [7:0]  bl_mask;                        // BL-1; 0xFF for full page
  logic        bl_full;
  logic [1:0]  cl;

  // active burst
  logic          b_act, b_wr, b_full;
  logic [1:0]    b_bank;
  logic [RW-1:0] b_row;
  logic [7:0]    b_c0, b_idx, b_mask, beat_col;

  // read pipeline: stage k holds a beat issued k cycles ago
  logic [2:0]        p_vld;
  logic [MEM_AW-1:0] p_addr [3];

  logic [2:0]        cmd;
  logic              cmd_en, is_act, is_rd, is_wr, is_pre, is_ref, is_mrs, is_bst, non_nop;
  logic              ready, any_open, a10, rw_ok, kill, bl_ok, cl_ok, proto_set;
  logic              iss_vld, iss_wr, src_vld;
  logic [MEM_AW-1:0] iss_addr, src_addr;
  logic              unused_row_bits;

  assign cmd      = {sdram_ras_n, sdram_cas_n, sdram_we_n};
  assign cmd_en   = sdram_cke & ~sdram_cs_n;
  assign is_act   = cmd_en && (cmd == C_ACT);
  assign is_rd    = cmd_en && (cmd == C_RD);
  assign is_wr    = cmd_en && (cmd == C_WR);
  assign is_pre   = cmd_en && (cmd == C_PRE);
  assign is_ref   = cmd_en && (cmd == C_REF);
  assign is_mrs   = cmd_en && (cmd == C_MRS);
  assign is_bst   = cmd_en && (cmd == C_BST);
  assign non_nop  = cmd_en && (cmd != C_NOP);
  assign a10      = sdram_addr[10];
  assign ready    = (state == READY);
  assign init_done = ready;
  assign any_open = |bank_open;
  assign rw_ok    = (is_rd | is_wr) & ready & bank_open[sdram_ba];
  assign kill     = is_bst | (is_pre & (a10 | (sdram_ba == b_bank)));
  assign bl_ok    = (sdram_addr[2:0] <= 3'd3) || (sdram_addr[2:0] == 3'd7);
  assign cl_ok    = (sdram_addr[6:4] == 3'd2) || (sdram_addr[6:4] == 3'd3);
  assign beat_col = (b_c0 & ~b_mask) | ((b_c0 + b_idx) & b_mask);
  assign src_vld  = (cl == 2'd3) ? p_vld[2]  : p_vld[1];
  assign src_addr = (cl == 2'd3) ? p_addr[2] : p_addr[1];
  assign unused_row_bits = ^{open_row[0], open_row[1], open_row[2], open_row[3]};

  // protocol violations seen this cycle
  always_comb begin
    proto_set = 1'b0;
    if ((is_act | is_rd | is_wr) && !ready)                   proto_set = 1'b1;
    if (is_act && ready && bank_open[sdram_ba])               proto_set = 1'b1;
    if ((is_rd | is_wr) && ready && !bank_open[sdram_ba])     proto_set = 1'b1;
    if (is_mrs && (any_open || !bl_ok || !cl_ok))             proto_set = 1'b1;
    if (is_ref && any_open)                                   proto_set = 1'b1;
  end

  // init state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= I_PRE;
      ref_cnt <= '0;
    end else begin
      state   <= state_nxt;
      ref_cnt <= ref_cnt_nxt;
    end
  end

  // init next state: PRE-all, INIT_REFS refreshes, then MRS
  always_comb begin
    state_nxt   = state;
    ref_cnt_nxt = ref_cnt;
    case (state)
      I_PRE: if (is_pre && a10) begin
        state_nxt   = I_REF;
        ref_cnt_nxt = '0;
      end
      I_REF: if (is_ref) begin
        if (ref_cnt == REFS_LAST) state_nxt = I_MRS;
        ref_cnt_nxt = ref_cnt + 1'b1;
      end
      I_MRS: if (is_mrs) state_nxt = READY;
      default: ;
    endcase
  end

  // beat issued this cycle: a fresh READ/WRITE wins, else the running burst continues
  always_comb begin
    iss_vld  = 1'b0;
    iss_wr   = 1'b0;
    iss_addr = '0;
    if (rw_ok) begin
      iss_vld  = 1'b1;
      iss_wr   = is_wr;
      iss_addr = {sdram_ba, open_row[sdram_ba][RW-1:0], sdram_addr[7:0]};
    end else if (b_act && sdram_cke && !kill) begin
      iss_vld  = 1'b1;
      iss_wr   = b_wr;
      iss_addr = {b_bank, b_row, beat_col};
    end
  end

  // bank, mode register and sticky protocol flag
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_open <= '0;
      for (int b = 0; b < 4; b++) open_row[b] <= '0;
      bl_mask   <= '0;
      bl_full   <= 1'b0;
      cl        <= 2'd3;
      proto_err <= 1'b0;
    end else begin
      if (is_act && ready) begin
        bank_open[sdram_ba] <= 1'b1;
        open_row[sdram_ba]  <= sdram_addr;
      end
      if (is_pre) begin
        if (a10) bank_open <= '0;
        else     bank_open[sdram_ba] <= 1'b0;
      end
      if (is_mrs && bl_ok) begin
        bl_full <= (sdram_addr[2:0] == 3'd7);
        bl_mask <= (sdram_addr[2:0] == 3'd7) ? 8'hFF : ((8'd1 << sdram_addr[2:0]) - 8'd1);
      end
      if (is_mrs && cl_ok) cl <= sdram_addr[5:4];
      proto_err <= proto_err | proto_set;
    end
  end

  // burst sequencer; the command cycle itself carries beat 0
  always_ff @(posedge clk) begin
    if (rst) begin
      b_act  <= 1'b0;
      b_wr   <= 1'b0;
      b_full <= 1'b0;
      b_bank <= '0;
      b_row  <= '0;
      b_c0   <= '0;
      b_idx  <= '0;
      b_mask <= '0;
    end else if (rw_ok) begin
      b_act  <= bl_full | (bl_mask != 8'd0);
      b_wr   <= is_wr;
      b_full <= bl_full;
      b_bank <= sdram_ba;
      b_row  <= open_row[sdram_ba][RW-1:0];
      b_c0   <= sdram_addr[7:0];
      b_idx  <= 8'd1;
      b_mask <= bl_mask;
    end else if (b_act) begin
      if (kill) begin
        b_act <= 1'b0;
      end else if (sdram_cke) begin
        b_idx <= b_idx + 8'd1;
        if (!b_full && (b_idx == b_mask)) b_act <= 1'b0;
      end
    end
  end

  // array write port; array is never cleared
  always_ff @(posedge clk) begin
    if (!rst && iss_vld && iss_wr) mem[iss_addr] <= dq_in;
  end

  // read pipeline and registered array read; an accepted WRITE flushes pending read data
  always_ff @(posedge clk) begin
    if (rst) begin
      p_vld  <= '0;
      for (int s = 0; s < 3; s++) p_addr[s] <= '0;
      dq_oe  <= 1'b0;
      dq_out <= '0;
    end else begin
      p_vld     <= {p_vld[1:0], iss_vld & ~iss_wr};
      p_addr[0] <= iss_addr;
      p_addr[1] <= p_addr[0];
      p_addr[2] <= p_addr[1];
      if (rw_ok && is_wr) begin
        p_vld  <= '0;
        dq_oe  <= 1'b0;
        dq_out <= '0;
      end else begin
        dq_oe  <= src_vld;
        dq_out <= src_vld ? mem[src_addr] : '0;
      end
    end
  end

`ifdef SDRAM_RESP_TIMING_CHK_EN
  localparam int TW = 5;
  localparam logic [TW-1:0] SAT = '1;

  logic [TW-1:0] act_age [4];
  logic [TW-1:0] pre_age [4];
  logic [TW-1:0] ref_age;
  logic          t_viol;

  assign t_viol = ((is_rd | is_wr) && (act_age[sdram_ba] < TW'(TRCD))) ||
                  (is_act && (pre_age[sdram_ba] < TW'(TRP))) ||
                  (non_nop && (ref_age < TW'(TRFC)));

  // saturating age counters: value equals cycles since the last event
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 4; b++) begin
        act_age[b] <= SAT;
        pre_age[b] <= SAT;
      end
      ref_age    <= SAT;
      timing_err <= 1'b0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (is_act && ready && (sdram_ba == 2'(b))) act_age[b] <= 1;
        else if (act_age[b] != SAT)                 act_age[b] <= act_age[b] + 1'b1;
        if (is_pre && (a10 || (sdram_ba == 2'(b)))) pre_age[b] <= 1;
        else if (pre_age[b] != SAT)                 pre_age[b] <= pre_age[b] + 1'b1;
      end
      if (is_ref)              ref_age <= 1;
      else if (ref_age != SAT) ref_age <= ref_age + 1'b1;
      timing_err <= timing_err | t_viol;
    end
  end
`else
  logic unused_timing;
  assign unused_timing = ^{TRCD, TRP, TRFC, non_nop};
  assign timing_err    = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_resp_model.sv
`timescale 1ns/1ps
// Bench for sdram_resp_model: drives command sequences, predicts read bursts into a scoreboard queue
// keyed by the cycle they must appear, and checks every dq_oe cycle against it.
module tb_sdram_resp_model;

  localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD  = 3'b101, C_WR  = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010, C_REF = 3'b001, C_MRS = 3'b000, C_BST = 3'b110;

`ifdef SDRAM_RESP_TIMING_CHK_EN
  localparam logic TCHK = 1'b1;
`else
  localparam logic TCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sdram_cke = 1'b1, sdram_cs_n = 1'b0;
  logic        sdram_ras_n = 1'b1, sdram_cas_n = 1'b1, sdram_we_n = 1'b1;
  logic [1:0]  sdram_ba = '0;
  logic [11:0] sdram_addr = '0;
  logic [15:0] dq_in = '0;
  logic [15:0] dq_out;
  logic        dq_oe, init_done, proto_err, timing_err;

  sdram_resp_model dut (
    .clk(clk), .rst(rst), .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n),
    .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_ba(sdram_ba), .sdram_addr(sdram_addr), .dq_in(dq_in), .dq_out(dq_out),
    .dq_oe(dq_oe), .init_done(init_done), .proto_err(proto_err), .timing_err(timing_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int cmd_cyc = 0;
  int bl = 1;
  int cl = 3;

  typedef struct { int cyc; logic [15:0] dat; } exp_t;
  exp_t        exp_q[$];
  logic [15:0] model [int];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int key(input int b, input int row, input int col);
    return b * 65536 + row * 256 + col;
  endfunction

  // column of beat i inside the burst-length block (full page wraps mod 256)
  function automatic int wrap(input int c0, input int i);
    int mask;
    mask = (bl == 256) ? 255 : bl - 1;
    return (c0 & ~mask) | ((c0 + i) & mask);
  endfunction

  task automatic tick(input logic [2:0] c, input logic [1:0] b, input logic [11:0] a, input logic [15:0] d);
    @(negedge clk);
    {sdram_ras_n, sdram_cas_n, sdram_we_n} = c;
    sdram_ba   = b;
    sdram_addr = a;
    dq_in      = d;
    cmd_cyc    = cyc + 1;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) tick(C_NOP, 2'd0, 12'h000, 16'h0000);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    {sdram_ras_n, sdram_cas_n, sdram_we_n} = C_NOP;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_burst(input logic [1:0] b, input int row, input int col, input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      tick((i == 0) ? C_WR : C_NOP, b, (i == 0) ? 12'(col) : 12'h000, base + 16'(i));
      model[key(b, row, wrap(col, i))] = base + 16'(i);
    end
  endtask

  // n = number of beats that must come out before the burst is cut short
  task automatic read_burst(input logic [1:0] b, input int row, input int col, input int n);
    exp_t e;
    tick(C_RD, b, 12'(col), 16'h0000);
    for (int i = 0; i < n; i++) begin
      e.cyc = cmd_cyc + cl + i;
      e.dat = model[key(b, row, wrap(col, i))];
      exp_q.push_back(e);
    end
  endtask

  // scoreboard: every dq_oe cycle must match the queue head, and no predicted beat may be skipped
  always @(negedge clk) begin
    if (dq_oe) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        check("rd_data", dq_out, exp_q[0].dat);
        void'(exp_q.pop_front());
      end else begin
        check("unexpected_oe", dq_oe, 0);
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      check("missing_oe", dq_oe, 1);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    // reset state
    do_reset();
    check("rst_dq_oe", dq_oe, 0);
    check("rst_dq_out", dq_out, 0);
    check("rst_init_done", init_done, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_timing_err", timing_err, 0);

    // READ before init: ignored, flagged
    tick(C_RD, 2'd1, 12'h010, 16'h0);
    nop(6);
    check("pre_init_rd_err", proto_err, 1);
    check("pre_init_done", init_done, 0);
    do_reset();
    check("err_cleared", proto_err, 0);

    // init: PRE-all, 2x REF, MRS BL=4 CL=3
    tick(C_PRE, 2'd0, 12'h400, 16'h0);
    nop(3);
    tick(C_REF, 2'd0, 12'h000, 16'h0);
    nop(8);
    tick(C_REF, 2'd0, 12'h000, 16'h0);
    nop(8);
    check("init_before_ref_done", init_done, 0);
    tick(C_MRS, 2'd0, 12'h032, 16'h0);
    bl = 4; cl = 3;
    check("init_before_mrs", init_done, 0);
    nop(1);
    check("init_done", init_done, 1);

    // write/read bank 1 row 5, in-block wrap, back-to-back reads
    tick(C_ACT, 2'd1, 12'd5, 16'h0);
    nop(3);
    write_burst(2'd1, 5, 8'h10, 4, 16'h00A0);
    nop(2);
    read_burst(2'd1, 5, 8'h10, 4);
    nop(3);
    read_burst(2'd1, 5, 8'h13, 4);
    nop(8);
    write_burst(2'd1, 5, 8'h16, 4, 16'h00B0);
    nop(2);
    read_burst(2'd1, 5, 8'h14, 4);
    nop(8);

    // read truncated by read, then read truncated by write
    read_burst(2'd1, 5, 8'h10, 2);
    nop(1);
    read_burst(2'd1, 5, 8'h14, 4);
    nop(8);
    tick(C_RD, 2'd1, 12'h010, 16'h0);
    write_burst(2'd1, 5, 8'h20, 4, 16'h00C0);
    nop(4);
    read_burst(2'd1, 5, 8'h20, 4);
    nop(8);
    check("no_err_yet", proto_err, 0);

    // WRITE to closed bank 2: flagged and dropped
    tick(C_ACT, 2'd2, 12'd5, 16'h0);
    nop(3);
    write_burst(2'd2, 5, 8'h10, 4, 16'h00D0);
    nop(1);
    tick(C_PRE, 2'd2, 12'h000, 16'h0);
    nop(4);
    tick(C_WR, 2'd2, 12'h010, 16'hDEAD);
    nop(3);
    check("wr_closed_err", proto_err, 1);
    tick(C_ACT, 2'd2, 12'd5, 16'h0);
    nop(3);
    read_burst(2'd2, 5, 8'h10, 4);
    nop(8);

    // full page: write/read across col 0xFF->0x00, cut by BST and PRE
    tick(C_PRE, 2'd0, 12'h400, 16'h0);
    nop(4);
    tick(C_MRS, 2'd0, 12'h037, 16'h0);
    bl = 256;
    nop(2);
    tick(C_ACT, 2'd1, 12'd5, 16'h0);
    nop(3);
    write_burst(2'd1, 5, 8'hFE, 4, 16'h00E0);
    tick(C_BST, 2'd0, 12'h000, 16'h9999);
    nop(2);
    read_burst(2'd1, 5, 8'hFE, 4);
    nop(3);
    tick(C_BST, 2'd0, 12'h000, 16'h0);
    nop(8);
    read_burst(2'd1, 5, 8'h00, 2);
    nop(1);
    tick(C_PRE, 2'd1, 12'h000, 16'h0);
    nop(8);

    // ACT then READ one cycle later: data returned, TRCD flagged only when checks are built in
    tick(C_PRE, 2'd0, 12'h400, 16'h0);
    nop(4);
    tick(C_MRS, 2'd0, 12'h032, 16'h0);
    bl = 4;
    nop(2);
    tick(C_ACT, 2'd3, 12'd5, 16'h0);
    nop(3);
    write_burst(2'd3, 5, 8'h00, 4, 16'h00F0);
    nop(1);
    tick(C_PRE, 2'd3, 12'h000, 16'h0);
    nop(4);
    check("timing_ok_so_far", timing_err, 0);
    tick(C_ACT, 2'd3, 12'd5, 16'h0);
    read_burst(2'd3, 5, 8'h00, 4);
    nop(8);
    check("trcd_timing_err", timing_err, 32'(TCHK));
    check("err_sticky", proto_err, 1);

    // reset in the middle of a read burst: only the first beat appears
    read_burst(2'd3, 5, 8'h00, 1);
    nop(3);
    do_reset();
    check("mid_rst_dq_oe", dq_oe, 0);
    check("mid_rst_init_done", init_done, 0);
    check("mid_rst_proto_err", proto_err, 0);
    check("mid_rst_timing_err", timing_err, 0);
    nop(6);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
